serial_pattern_generator: RTL
=============================

// Module: serial_pattern_generator
// PURPOSE
//  Serial transmitter: the source end of the button-strobed serial bit protocol.
//  On start it emits a fixed bit pattern, MSB first, on x_out, with one
//  shift_out strobe per bit. The default pattern is 1100110.
//  The pattern repeats a programmable number of times, with idle gaps between copies.
//  Drives the serial-pattern detector (x/shift inputs) on-chip, or via GPIO for board test.
// PARAMETERS
//  PAT_W    7            pattern length in bits (2..16)
//  PATTERN  7'b1100110   pattern; bit PAT_W-1 is sent first
//  DIV      25_000_000   CLOCK_50 cycles per bit period (even, >=4)
//  GAP_BITS 2            idle bit periods between repetitions (>=1)
//  REP_W    4            width of reps input
// PORTS
//  CLOCK_50      in   1      system clock, 50 MHz
//  rst           in   1      asynchronous reset, active-high
//  start         in   1      request; sampled each edge, acted on only in IDLE
//  abort         in   1      synchronous abort of a transfer in progress
//  reps          in   REP_W  number of pattern copies; 0 treated as 1; sampled on start
//  x_out         out  1      serial data bit
//  shift_out     out  1      1-cycle strobe, mid-bit; receiver samples x_out on it
//  busy          out  1      high in SEND/GAP/DONE
//  done          out  1      1-cycle pulse after the last bit of the last copy
//  diods         out  10     history of strobed bits, newest in bit 0
//  currentState  out  3      FSM state for debug/LEDs
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; x_out, shift_out, busy, done = 0;
//   diods=0; all internal counters=0.
//  States (currentState): IDLE=0, SEND=1, GAP=2, DONE=3; other codes -> IDLE.
//  All outputs are registered; no combinational path from inputs to outputs.
//  IDLE, start=1, abort=0, at edge E0:
//   - state->SEND; bit_cnt=0; prescaler cnt=0
//   - rep_left = (reps==0) ? 1 : reps
//   - x_out = PATTERN[PAT_W-1]
//  Bit period: cnt counts 0..DIV-1.
//   - shift_out=1 exactly in the cycle where cnt==DIV/2 (SEND only).
//   - On that strobe: diods <= {diods[8:0], x_out}.
//   - At cnt==DIV-1: cnt->0 and the next bit is loaded onto x_out.
//  Timing: x_out is stable for DIV/2 cycles before the strobe and DIV/2-1 cycles after it.
//  SEND: after bit_cnt==PAT_W-1 completes its period:
//   - rep_left>1: rep_left--, go to GAP, x_out=0.
//   - rep_left==1: go to DONE.
//  GAP: GAP_BITS*DIV cycles, x_out=0, no strobes. Then SEND with bit_cnt=0 and the
//   first pattern bit on x_out.
//  DONE: one cycle with done=1 and busy=1, then IDLE. x_out=0 in DONE and IDLE.
//  abort=1 in SEND/GAP/DONE: next edge -> IDLE.
//   - x_out=0, shift_out=0, no done pulse; diods keep their value.
//   - abort has priority over start, strobe and state advance.
//  start in IDLE with abort=1: ignored (stay IDLE).
//  start while busy: ignored. reps is not resampled mid-transfer.
//  A new start is accepted in the IDLE cycle right after DONE (no extra dead cycles).
//  Total strobes per transfer = PAT_W * rep_left.
//  Counter widths: cnt holds DIV-1; rep counter holds 2^REP_W-1; no wrap inside a transfer.
// TESTING (run with DIV=4, GAP_BITS=2, default pattern)
//  1. Assert rst mid-run, then release: all outputs 0 and state IDLE, with no clock edge needed.
//  2. start, reps=1:
//     - shift_out high in cycles 2,6,...,26 after E0
//     - x_out at the strobes = 1,1,0,0,1,1,0
//     - done=1 in cycle 28; diods=10'b0001100110
//  3. reps=3:
//     - 21 strobes in total, 3 groups of 7
//     - 8-cycle gaps with x_out=0 and no strobes between groups
//     - exactly one done pulse
//  4. reps=0: identical trace to scenario 2.
//  5. abort in the cycle after the 3rd strobe:
//     - IDLE next edge, no done
//     - diods=10'b0000000110
//     - a following start runs a full, clean transfer
//  6. start pulsed during SEND, and start+abort in IDLE: both ignored.
//     A back-to-back start in the cycle after done is accepted.
//  7. Loopback into the detector: its y output goes high after the 7th strobe of each copy.

Source files
------------

// File: rtl/serial_pattern_generator.sv
// -----------------------------------------------------------------------------
// serial_pattern_generator
//
// Source end of the button-strobed serial bit protocol. On start it sends a
// fixed PAT_W-bit pattern MSB first on x_out. Each bit period is DIV clock
// cycles long, and shift_out gives a one-cycle strobe in the middle of each
// bit. The pattern is repeated reps times (0 counts as 1). Copies are
// separated by GAP_BITS idle bit periods with x_out low and no strobes.
//
// Ports
//   CLOCK_50      in   1      system clock
//   rst           in   1      asynchronous reset, active-high
//   start         in   1      transfer request, acted on only in IDLE
//   abort         in   1      synchronous abort of a transfer in progress
//   reps          in   REP_W  number of pattern copies (0 -> 1), sampled on start
//   x_out         out  1      serial data bit
//   shift_out     out  1      one-cycle mid-bit strobe
//   busy          out  1      high in SEND / GAP / DONE
//   done          out  1      one-cycle pulse after the last bit of the last copy
//   diods         out  10     history of strobed bits, newest in bit 0
//   currentState  out  3      FSM state (IDLE=0, SEND=1, GAP=2, DONE=3)
//
// All outputs are registered. The combinational block computes the
// next-cycle value of every output.
// -----------------------------------------------------------------------------
module serial_pattern_generator #(
    parameter int               PAT_W    = 7,
    parameter logic [PAT_W-1:0] PATTERN  = 7'b1100110,
    parameter int               DIV      = 25_000_000,
    parameter int               GAP_BITS = 2,
    parameter int               REP_W    = 4
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [REP_W-1:0] reps,
    output logic             x_out,
    output logic             shift_out,
    output logic             busy,
    output logic             done,
    output logic [9:0]       diods,
    output logic [2:0]       currentState
);

    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;     // cycle within the current bit period
    logic [BIT_W-1:0]   bit_q,   bit_d;     // bit index within the current copy
    logic [GAP_W-1:0]   gap_q,   gap_d;     // idle bit period within a gap
    logic [REP_W-1:0]   rep_q,   rep_d;     // copies still to send, including the current one
    logic [PAT_W-1:0]   sr_q,    sr_d;      // pattern shifter, MSB is the bit on x_out
    logic               x_q,     x_d;
    logic               shift_q, shift_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [9:0]         diods_q, diods_d;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            sr_q    <= '0;
            x_q     <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diods_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            sr_q    <= sr_d;
            x_q     <= x_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diods_q <= diods_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        sr_d    = sr_q;
        x_d     = x_q;
        done_d  = 1'b0;
        diods_d = diods_q;

        case (state_q)
            S_IDLE: begin
                x_d = 1'b0;
                if (start && !abort) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                    bit_d   = '0;
                    gap_d   = '0;
                    rep_d   = (reps == '0) ? REP_W'(1) : reps;
                    sr_d    = PATTERN;
                    x_d     = PATTERN[PAT_W-1];
                end
            end

            S_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        x_d = 1'b0;
                        if (rep_q > REP_W'(1)) begin
                            rep_d   = rep_q - REP_W'(1);
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        sr_d  = sr_q << 1;
                        // Next bit is the one just below the current MSB.
                        x_d   = sr_q[PAT_W-2];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                x_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (gap_q == GAP_LAST) begin
                        state_d = S_SEND;
                        bit_d   = '0;
                        sr_d    = PATTERN;
                        x_d     = PATTERN[PAT_W-1];
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                x_d     = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                x_d     = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything except the strobe history.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            gap_d   = '0;
            rep_d   = '0;
            x_d     = 1'b0;
            done_d  = 1'b0;
        end

        // The strobe is registered, so it is derived from next-cycle state and count.
        shift_d = (state_d == S_SEND) && (cnt_d == CNT_MID);
        if (shift_d) begin
            diods_d = {diods_q[8:0], x_d};
        end

        busy_d = (state_d != S_IDLE);
    end

    assign x_out        = x_q;
    assign shift_out    = shift_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign diods        = diods_q;
    assign currentState = state_q;

endmodule
